// File: rtl/addr_decode_mc.sv
// Samples an asynchronous strobe/word pair, splits each word into address and data,
// and updates one of NUM_CH channel registers; a watchdog drops the link when strobes stop.
// Optional feature: define PARITY_CHECK_EN for an even-parity bit and an error counter.
module addr_decode_mc #(
    parameter  int WORD_W      = 16,
    parameter  int ADDR_W      = 2,
    parameter  int SYNC_STAGES = 2,
    parameter  int TIMEOUT     = 16,
    localparam int NUM_CH      = 2 ** ADDR_W,
`ifdef PARITY_CHECK_EN
    localparam int DATA_W      = WORD_W - ADDR_W - 1
`else
    localparam int DATA_W      = WORD_W - ADDR_W
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ext_clk,
    input  logic [WORD_W-1:0]        ext_data,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_valid,
    output logic                     link_up,
`ifdef PARITY_CHECK_EN
    output logic [15:0]              parity_err_cnt,
`endif
    output logic [15:0]              word_count
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [SYNC_STAGES-1:0]             clk_sync_q;
    logic [SYNC_STAGES-1:0][WORD_W-1:0] data_sync_q;
    logic                               clk_prev_q;
    logic                               edge_d;

    logic                               s1_edge_q;
    logic [WORD_W-1:0]                  s1_word_q;
    logic                               parity_ok;

    logic                               s2_edge_q;
    logic                               s2_ok_q;
    logic                               s2_perr_q;
    logic [ADDR_W-1:0]                  s2_addr_q;
    logic [DATA_W-1:0]                  s2_data_q;

    logic [NUM_CH-1:0][DATA_W-1:0]      ch_q,   ch_d;
    logic [NUM_CH-1:0]                  vld_q,  vld_d;
    logic                               link_q, link_d;
    logic [WD_W-1:0]                    wd_q,   wd_d;
    logic [15:0]                        cnt_q,  cnt_d;
    logic [15:0]                        perr_q, perr_d;

    // Strobe and word travel through identically deep chains so the word is
    // captured in the same cycle the synchronised strobe shows its rising edge.
    assign edge_d = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;

`ifdef PARITY_CHECK_EN
    assign parity_ok = ~^s1_word_q;
`else
    assign parity_ok = 1'b1;
`endif

    // NOTE: state is updated with non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            clk_prev_q  <= 1'b0;
            s1_edge_q   <= 1'b0;
            s1_word_q   <= '0;
            s2_edge_q   <= 1'b0;
            s2_ok_q     <= 1'b0;
            s2_perr_q   <= 1'b0;
            s2_addr_q   <= '0;
            s2_data_q   <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ext_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ext_data};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
            s1_edge_q   <= edge_d;
            s1_word_q   <= data_sync_q[SYNC_STAGES-1];
            s2_edge_q   <= s1_edge_q;
            s2_ok_q     <= s1_edge_q & parity_ok;
            s2_perr_q   <= s1_edge_q & ~parity_ok;
            s2_addr_q   <= s1_word_q[WORD_W-1 -: ADDR_W];
            s2_data_q   <= s1_word_q[DATA_W-1:0];
        end
    end

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        ch_d   = ch_q;
        vld_d  = '0;
        link_d = link_q;
        wd_d   = wd_q;
        cnt_d  = cnt_q;
        perr_d = perr_q;

        if (s2_edge_q) begin
            // A strobe edge beats a coincident timeout and revives a dead link.
            wd_d   = '0;
            link_d = 1'b1;
            if (s2_ok_q) begin
                ch_d[s2_addr_q]  = s2_data_q;
                vld_d[s2_addr_q] = 1'b1;
                if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            end
        end else begin
            if (wd_q == WD_W'(TIMEOUT - 1)) begin
                link_d = 1'b0;
                ch_d   = '0;
            end
            if (wd_q != WD_W'(TIMEOUT)) wd_d = wd_q + WD_W'(1);
        end

        if (s2_perr_q && perr_q != 16'hFFFF) perr_d = perr_q + 16'd1;
    end

    // NOTE: the channel registers are reset explicitly; they are flops, not a
    // RAM, and must read as zero straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q   <= '0;
            vld_q  <= '0;
            link_q <= 1'b0;
            wd_q   <= '0;
            cnt_q  <= '0;
            perr_q <= '0;
        end else begin
            ch_q   <= ch_d;
            vld_q  <= vld_d;
            link_q <= link_d;
            wd_q   <= wd_d;
            cnt_q  <= cnt_d;
            perr_q <= perr_d;
        end
    end

    assign ch_data    = ch_q;
    assign ch_valid   = vld_q;
    assign link_up    = link_q;
    assign word_count = cnt_q;
`ifdef PARITY_CHECK_EN
    assign parity_err_cnt = perr_q;
`else
    logic unused_perr;
    assign unused_perr = ^perr_q;
`endif

endmodule

// File: tb/tb_addr_decode_mc.sv
// Directed bench for addr_decode_mc: latency, channel decode, watchdog timeout,
// edge/timeout coincidence, mid-word reset and (with PARITY_CHECK_EN) parity errors.
module tb_addr_decode_mc;

    localparam int S      = 2;
    localparam int T      = 16;
    localparam int NUM_CH = 4;
`ifdef PARITY_CHECK_EN
    localparam int DW = 13;
`else
    localparam int DW = 14;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ext_clk;
    logic [15:0]          ext_data;
    logic [NUM_CH*DW-1:0] ch_data;
    logic [NUM_CH-1:0]    ch_valid;
    logic                 link_up;
    logic [15:0]          word_count;
`ifdef PARITY_CHECK_EN
    logic [15:0]          parity_err_cnt;
`endif

    addr_decode_mc #(
        .WORD_W(16), .ADDR_W(2), .SYNC_STAGES(S), .TIMEOUT(T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ext_clk    (ext_clk),
        .ext_data   (ext_data),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .link_up    (link_up),
`ifdef PARITY_CHECK_EN
        .parity_err_cnt(parity_err_cnt),
`endif
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cyc   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] chan(input int k);
        return ch_data[k*DW +: DW];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Strobe one word; the write must land exactly S+2 edges after the first
    // edge that samples ext_clk high, and produce a single valid pulse.
    task automatic strobe(input logic [15:0] w, input logic [3:0] exp_vld, input string tag);
        int pulses;
        pulses = 0;
        @(negedge clk);
        ext_data = w;
        repeat (S + 2) @(negedge clk);
        ext_clk = 1'b1;
        for (int k = 0; k <= S + 2; k++) begin
            @(posedge clk); #1;
            if (k == S + 1) check({tag, "_early"}, ch_valid, 0);
            if (k == S + 2) begin
                check({tag, "_vld"}, ch_valid, exp_vld);
                wr_cyc = cyc;
            end
            if (ch_valid != 0) pulses++;
        end
        @(negedge clk);
        ext_clk = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ch_valid != 0) pulses++;
        end
        check({tag, "_pulses"}, pulses, (exp_vld != 0) ? 1 : 0);
    endtask

    logic [15:0]   t2_word [4] = '{16'h1111, 16'h5222, 16'h9333, 16'hD444};
    logic [DW-1:0] t2_data [4] = '{'h1111, 'h1222, 'h1333, 'h1444};
    logic [3:0]    t2_vld  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        int pulses;
        int target;
        rst      = 1'b1;
        ext_clk  = 1'b0;
        ext_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_ch_data", ch_data, 0);
        check("rst_ch_valid", ch_valid, 0);
        check("rst_link_up", link_up, 0);
        check("rst_word_count", word_count, 0);

`ifdef PARITY_CHECK_EN
        strobe(16'hA123, 4'b0100, "p_good");
        strobe(16'hA122, 4'b0000, "p_bad");
        check("p_word_count", word_count, 1);
        check("p_err_cnt", parity_err_cnt, 1);
        check("p_link_up", link_up, 1);
        check("p_ch2", chan(2), 'h0123);
`else
        // Test 1: single word to channel 2
        strobe(16'h8123, 4'b0100, "t1");
        check("t1_ch2", chan(2), 'h0123);
        check("t1_link_up", link_up, 1);
        check("t1_word_count", word_count, 1);

        // Test 2: one word per channel after a fresh reset
        do_reset();
        for (int k = 0; k < 4; k++) strobe(t2_word[k], t2_vld[k], $sformatf("t2_%0d", k));
        for (int k = 0; k < 4; k++) check($sformatf("t2_ch%0d", k), chan(k), t2_data[k]);
        check("t2_word_count", word_count, 4);

        // Test 3: strobe stops; link drops exactly T clocks after the last write
        target = wr_cyc + T - 1;
        while (cyc < target) begin @(posedge clk); #1; end
        check("t3_link_before", link_up, 1);
        check("t3_ch0_before", chan(0), 'h1111);
        @(posedge clk); #1;
        check("t3_link_drop", link_up, 0);
        check("t3_ch_cleared", ch_data, 0);
        check("t3_count_kept", word_count, 4);
        strobe(16'hC00A, 4'b1000, "t3r");
        check("t3r_link_up", link_up, 1);
        check("t3r_ch3", chan(3), 'h000A);
        check("t3r_ch0", chan(0), 0);

        // Test 4: next write lands on the cycle the watchdog sits at T-1
        target = wr_cyc + T - 2 * S - 5;
        while (cyc < target) begin @(posedge clk); #1; end
        strobe(16'h4555, 4'b0010, "t4");
        check("t4_link_up", link_up, 1);
        check("t4_ch1", chan(1), 'h0555);
        check("t4_ch3_kept", chan(3), 'h000A);
        check("t4_word_count", word_count, 6);

        // Test 5: reset one clock after the rise is sampled discards the word
        @(negedge clk);
        ext_data = 16'h2777;
        repeat (S + 2) @(negedge clk);
        ext_clk = 1'b1;
        @(negedge clk);
        rst    = 1'b1;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (ch_valid != 0) pulses++;
            @(negedge clk);
            if (i == 3) ext_clk = 1'b0;
            if (i == 7) rst = 1'b0;
        end
        check("t5_no_valid", pulses, 0);
        check("t5_ch_data", ch_data, 0);
        check("t5_link_up", link_up, 0);
        check("t5_word_count", word_count, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
